// File: rtl/toeplitz_pkg.sv
`default_nettype none
// ============================================================================
// Module  : toeplitz_pkg
// Brief   : Shared defaults (N, L, SEED) for the Toeplitz hasher, the
//           downstream serializer and their benches, plus a direct
//           matrix-product reference model.
// Revision: 1.0 - initial release
// ============================================================================
package toeplitz_pkg;

    // Raw bits per block, output word width, and the default seed.
    localparam int TOEPLITZ_N = 16;
    localparam int TOEPLITZ_L = 8;
    localparam logic [TOEPLITZ_N+TOEPLITZ_L-2:0] TOEPLITZ_SEED = 23'h2D5A93;

    typedef logic [TOEPLITZ_N-1:0]            toeplitz_block_t;
    typedef logic [TOEPLITZ_N+TOEPLITZ_L-2:0] toeplitz_seed_t;
    typedef logic [TOEPLITZ_L-1:0]            toeplitz_word_t;

    // Straight matrix-vector product over GF(2). d[j] is the j-th accepted
    // bit of the block (d[0] arrives first).
    function automatic toeplitz_word_t toeplitz_ref(input toeplitz_block_t d,
                                                    input toeplitz_seed_t  s);
        toeplitz_word_t r;
        r = '0;
        for (int k = 0; k < TOEPLITZ_L; k++) begin
            for (int j = 0; j < TOEPLITZ_N; j++) begin
                r[k] = r[k] ^ (d[j] & s[TOEPLITZ_N-1-j+k]);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/toeplitz_hash.sv
`default_nettype none
// ============================================================================
// Module  : toeplitz_hash
// Brief   : Bit-serial Toeplitz hasher over GF(2). Compresses each block of
//           N accepted bits into an L-bit word and strobes it for one cycle.
//           Optional macro TOEPLITZ_SEED_PORT_EN adds a runtime-loadable
//           seed register (seed / seed_load ports).
// Revision: 1.0 - initial release
// ============================================================================
module toeplitz_hash
    import toeplitz_pkg::*;
#(
    parameter int             N    = TOEPLITZ_N,
    parameter int             L    = TOEPLITZ_L,
    parameter logic [N+L-2:0] SEED = TOEPLITZ_SEED
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         dbit,
    input  logic         dbiten,
    output logic [L-1:0] q,
    output logic         qstrobe
`ifdef TOEPLITZ_SEED_PORT_EN
    ,
    input  logic [N+L-2:0] seed,
    input  logic           seed_load
`endif
);

    localparam int            CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [L-1:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [L-1:0]   q_q, q_d;
    logic           qstrobe_q, qstrobe_d;
    logic [N+L-2:0] seed_act;
    logic [N+L-2:0] seed_shift;
    logic [L-1:0]   seed_term;

`ifdef TOEPLITZ_SEED_PORT_EN
    logic [N+L-2:0] seed_q;

    // Active seed register; a load replaces it on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seed_q <= SEED;
        end else if (seed_load) begin
            seed_q <= seed;
        end
    end

    assign seed_act = seed_q;
`else
    assign seed_act = SEED;
`endif

    // Bit number cnt uses the seed window starting at N-1-cnt; the last bit
    // of a block (cnt = N-1) therefore lands on the window starting at 0.
    assign seed_shift = seed_act >> (CNT_LAST - cnt_q);
    assign seed_term  = dbit ? seed_shift[L-1:0] : '0;

    // Next-state: accumulate, or close the block and publish the word.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        qstrobe_d = 1'b0;
`ifdef TOEPLITZ_SEED_PORT_EN
        if (seed_load) begin
            // Abort the block; any bit offered this cycle is dropped.
            acc_d = '0;
            cnt_d = '0;
        end else if (dbiten) begin
`else
        if (dbiten) begin
`endif
            if (cnt_q == CNT_LAST) begin
                q_d       = acc_q ^ seed_term;
                qstrobe_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
            end else begin
                acc_d = acc_q ^ seed_term;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Datapath registers; reset discards any partial block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            q_q       <= '0;
            qstrobe_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            qstrobe_q <= qstrobe_d;
        end
    end

    assign q       = q_q;
    assign qstrobe = qstrobe_q;

endmodule
`default_nettype wire

// File: tb/tb_toeplitz_hash.sv
`default_nettype none
// ============================================================================
// Module  : tb_toeplitz_hash
// Brief   : Directed bench for toeplitz_hash (N=4, L=2, seed 5'b10110) plus
//           random blocks on a default-parameter instance checked against
//           toeplitz_ref.
// Revision: 1.0 - initial release
// ============================================================================
module tb_toeplitz_hash;
    import toeplitz_pkg::*;

    localparam int             TN    = 4;
    localparam int             TL    = 2;
    localparam logic [TN+TL-2:0] TSEED = 5'b10110;

    logic          clk = 1'b0;
    logic          reset;
    logic          dbit, dbiten;
    logic [TL-1:0] q;
    logic          qstrobe;

    logic                  dbit16, dbiten16;
    logic [TOEPLITZ_L-1:0] q16;
    logic                  qs16;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [TN-1:0] bits;   // bits[0] is sent first
        logic [TL-1:0] exp_q;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    toeplitz_hash #(.N(TN), .L(TL), .SEED(TSEED)) dut (
        .clk     (clk),
        .reset   (reset),
        .dbit    (dbit),
        .dbiten  (dbiten),
        .q       (q),
        .qstrobe (qstrobe)
    );

    toeplitz_hash dut16 (
        .clk     (clk),
        .reset   (reset),
        .dbit    (dbit16),
        .dbiten  (dbiten16),
        .q       (q16),
        .qstrobe (qs16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        dbit   = b;
        dbiten = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        dbit   = 1'b0;
        dbiten = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int          pulses;
        int          cbits [12];
        logic [1:0]  cexp  [3];
        int          gbits [4];
        logic [15:0] blk;

        // Hand-computed with s = 10110 (s4..s0): q[k] = XOR_j d_j & s[3-j+k]
        vecs[0] = '{bits: 4'b0010, exp_q: 2'b01};  // 0,1,0,0
        vecs[1] = '{bits: 4'b0100, exp_q: 2'b11};  // 0,0,1,0
        vecs[2] = '{bits: 4'b0001, exp_q: 2'b10};  // 1,0,0,0
        vecs[3] = '{bits: 4'b0000, exp_q: 2'b00};  // 0,0,0,0
        vecs[4] = '{bits: 4'b1111, exp_q: 2'b10};  // 1,1,1,1
        vecs[5] = '{bits: 4'b1000, exp_q: 2'b10};  // 0,0,0,1

        cbits = '{0,1,0,0, 0,0,1,0, 1,1,1,1};
        cexp  = '{2'b01, 2'b11, 2'b10};
        gbits = '{0,1,0,0};

        reset    = 1'b1;
        dbit     = 1'b0;
        dbiten   = 1'b0;
        dbit16   = 1'b0;
        dbiten16 = 1'b0;
        repeat (2) tick();
        chk("reset_q", 32'(q), 32'h0);
        chk("reset_qstrobe", 32'(qstrobe), 32'h0);
        chk("reset_q16", 32'(q16), 32'h0);
        reset = 1'b0;
        tick();

        // Table-driven single blocks, each followed by one idle cycle
        for (int i = 0; i < 6; i++) begin
            for (int b = 0; b < TN; b++) begin
                send(vecs[i].bits[b]);
                if (b < TN - 1)
                    chk($sformatf("vec%0d_early_strobe%0d", i, b), 32'(qstrobe), 32'h0);
            end
            chk($sformatf("vec%0d_strobe", i), 32'(qstrobe), 32'h1);
            chk($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
            idle(1);
            chk($sformatf("vec%0d_strobe_drop", i), 32'(qstrobe), 32'h0);
            chk($sformatf("vec%0d_q_hold", i), 32'(q), 32'(vecs[i].exp_q));
        end

        // 12 continuous bits: strobes exactly every 4 cycles
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            send(cbits[i][0]);
            if (qstrobe) pulses++;
            if (i % 4 == 3) begin
                chk($sformatf("cont_strobe%0d", i), 32'(qstrobe), 32'h1);
                chk($sformatf("cont_q%0d", i / 4), 32'(q), 32'(cexp[i / 4]));
            end else begin
                chk($sformatf("cont_nostrobe%0d", i), 32'(qstrobe), 32'h0);
            end
        end
        idle(1);
        chk("cont_pulses", 32'(pulses), 32'd3);

        // Gapped: 3 idle cycles between every pair of bits
        pulses = 0;
        for (int b = 0; b < 4; b++) begin
            send(gbits[b][0]);
            if (qstrobe) pulses++;
            if (b < 3) begin
                for (int g = 0; g < 3; g++) begin
                    idle(1);
                    if (qstrobe) pulses++;
                end
            end
        end
        chk("gap_q", 32'(q), 32'h1);
        idle(2);
        if (qstrobe) pulses++;
        chk("gap_pulses", 32'(pulses), 32'd1);

        // Make q nonzero, then reset mid-block
        send(1'b1); send(1'b0); send(1'b0); send(1'b0);
        chk("prereset_q", 32'(q), 32'h2);
        send(1'b1);
        send(1'b1);
        dbiten = 1'b0;
        reset  = 1'b1;
        #1;
        chk("midreset_q", 32'(q), 32'h0);
        chk("midreset_qstrobe", 32'(qstrobe), 32'h0);
        tick();
        reset = 1'b0;
        for (int b = 0; b < 4; b++) begin
            send(gbits[b][0]);
            if (b < 3)
                chk($sformatf("postreset_early_strobe%0d", b), 32'(qstrobe), 32'h0);
        end
        chk("postreset_strobe", 32'(qstrobe), 32'h1);
        chk("postreset_q", 32'(q), 32'h1);
        idle(1);

        // Default-parameter instance: random blocks with random gaps
        for (int k = 0; k < 8; k++) begin
            blk = 16'($urandom);
            for (int j = 0; j < TOEPLITZ_N; j++) begin
                dbit16   = blk[j];
                dbiten16 = 1'b1;
                tick();
                if (j < TOEPLITZ_N - 1) begin
                    if (qs16) begin
                        failures++;
                        checks++;
                        $display("FAIL rnd%0d_early_strobe actual=1 expected=0", k);
                    end
                    if ($urandom_range(0, 3) == 0) begin
                        dbiten16 = 1'b0;
                        tick();
                    end
                end
            end
            dbiten16 = 1'b0;
            chk($sformatf("rnd%0d_strobe", k), 32'(qs16), 32'h1);
            chk($sformatf("rnd%0d_q", k), 32'(q16),
                32'(toeplitz_ref(blk, TOEPLITZ_SEED)));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
